// File: rtl/flag_unit_pkg.sv
// Shared encodings for the NZCV flag unit: branch types, ARMv8 condition codes,
// NZCV bit positions and the result-holding FSM states.
package flag_unit_pkg;

  typedef enum logic [1:0] {
    BR_B     = 2'b00,
    BR_BCOND = 2'b01,
    BR_CBZ   = 2'b10,
    BR_CBNZ  = 2'b11
  } br_type_e;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_HS = 4'b0010;
  localparam logic [3:0] COND_LO = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions inside the {N,Z,C,V} vector
  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/flag_unit_cond_eval.sv
// Combinational ARMv8 condition-code evaluator over an {N,Z,C,V} vector.
// Zero latency, no flow control.
module cond_eval
  import flag_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = nzcv[NZCV_N];
  assign w_z = nzcv[NZCV_Z];
  assign w_c = nzcv[NZCV_C];
  assign w_v = nzcv[NZCV_V];

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = w_z;
      COND_NE: pass = ~w_z;
      COND_HS: pass = w_c;
      COND_LO: pass = ~w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = ~w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = ~w_v;
      COND_HI: pass = w_c & ~w_z;
      COND_LS: pass = ~(w_c & ~w_z);
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = ~w_z & (w_n == w_v);
      COND_LE: pass = ~(~w_z & (w_n == w_v));
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// NZCV flag register plus branch resolver; 1-cycle accept-to-result latency, result
// held until res_ack, back-to-back accept when acked, flush drops any held result.
module flag_unit
  import flag_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic       ex_setflags,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  input  logic       alu_carry_out,
  input  logic       br_valid,
  input  logic [1:0] br_type,
  input  logic [3:0] br_cond,
  input  logic       br_regzero,
  output logic       br_ready,
  output logic       res_valid,
  output logic       res_taken,
  input  logic       res_ack,
  input  logic       flush,
  output logic [3:0] flags_q
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [3:0] r_flags;
  logic       r_taken;

  logic       w_flag_wr;
  logic [3:0] w_alu_nzcv;
  logic [3:0] w_eff_flags;
  logic       w_cond_pass;
  logic       w_taken;
  logic       w_accept;

  assign w_flag_wr  = ex_valid & ex_setflags;
  assign w_alu_nzcv = {alu_negative, alu_zero, alu_carry_out, alu_overflow};

  // Forward the ALU flags so a branch paired with ADDS/SUBS sees the new NZCV
  assign w_eff_flags = w_flag_wr ? w_alu_nzcv : r_flags;

  cond_eval u_cond_eval (
    .cond (br_cond),
    .nzcv (w_eff_flags),
    .pass (w_cond_pass)
  );

  always_comb begin
    w_taken = 1'b1;
    case (br_type_e'(br_type))
      BR_B:     w_taken = 1'b1;
      BR_BCOND: w_taken = w_cond_pass;
      BR_CBZ:   w_taken = br_regzero;
      BR_CBNZ:  w_taken = ~br_regzero;
      default:  w_taken = 1'b1;
    endcase
  end

  assign br_ready = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & res_ack);
  assign w_accept = br_valid & br_ready & ~flush;

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else if (w_accept) begin
      w_state_nxt = ST_HOLD;
    end else if ((r_state == ST_HOLD) & res_ack) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flag writes proceed regardless of flush: they belong to the EX instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else if (w_flag_wr) begin
      r_flags <= w_alu_nzcv;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_taken <= 1'b0;
    end else if (w_accept) begin
      r_taken <= w_taken;
    end
  end

  assign res_valid = (r_state == ST_HOLD);
  assign res_taken = r_taken;
  assign flags_q   = r_flags;

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; asserting (0) clears all state immediately, release is synchronous to clk.
REQ-003 ex_valid  input  1  an instruction occupies EX this cycle.
REQ-004 ex_setflags  input  1  the EX instruction writes NZCV (ADDS/SUBS); ignored unless ex_valid.
REQ-005 alu_negative, alu_zero, alu_overflow, alu_carry_out  input  1 each  ALU flag outputs for the EX instruction.
REQ-006 br_valid  input  1  decode presents a branch for resolution.
REQ-007 br_type  input  2  00 B (unconditional), 01 B.cond, 10 CBZ, 11 CBNZ.
REQ-008 br_cond  input  4  ARMv8 condition field for B.cond.
REQ-009 br_regzero  input  1  tested register equals zero (CBZ/CBNZ).
REQ-010 br_ready  output  1  unit can accept a branch this cycle.
REQ-011 res_valid  output  1  resolution result is held on res_taken.
REQ-012 res_taken  output  1  branch taken; meaningful only while res_valid.
REQ-013 res_ack  input  1  fetch consumes the result.
REQ-014 flush  input  1  discard any pending or held branch.
REQ-015 flags_q  output  4  architectural NZCV register, bit order {N,Z,C,V}.

Function
REQ-016 Flag write: on a clock edge with ex_valid & ex_setflags, flags_q SHALL load {alu_negative, alu_zero, alu_carry_out, alu_overflow}; otherwise flags_q holds.
REQ-017 Effective flags for evaluation SHALL be the ALU flags when ex_valid & ex_setflags in the accept cycle (forwarding), else flags_q.
REQ-018 Conditions: EQ 0000 Z; NE 0001 !Z; HS 0010 C; LO 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V; HI 1000 C&!Z; LS 1001 !(C&!Z); GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 !(!Z&(N==V)); 1110/1111 always true.
REQ-019 Taken: B always 1; B.cond per REQ-018; CBZ = br_regzero; CBNZ = !br_regzero.
REQ-020 FSM states IDLE, HOLD; br_ready = (state==IDLE) | (state==HOLD & res_ack).
REQ-021 IDLE: br_valid & br_ready & !flush SHALL register res_taken, set res_valid, go to HOLD on the next edge (latency 1 cycle, accept-to-res_valid).
REQ-022 HOLD: res_valid and res_taken SHALL stay stable until res_ack; res_ack without new br_valid returns to IDLE with res_valid=0.
REQ-023 HOLD with res_ack & br_valid same cycle: new branch accepted back-to-back, state stays HOLD, res_taken updated, res_valid stays 1 (one result per cycle throughput).
REQ-024 flush SHALL have priority over accept and ack: next state IDLE, res_valid=0, no branch accepted that cycle; flags_q update per REQ-016 is unaffected by flush.
REQ-025 A simultaneous flag write and B.cond accept SHALL evaluate on the forwarded (new) flags, never the stale flags_q.

Reset
REQ-026 While reset=0: state=IDLE, flags_q=4'b0000, res_valid=0, res_taken=0; br_ready=1 after release.
REQ-027 Reset asserted mid-HOLD SHALL drop res_valid within the same cycle (asynchronous), with no res_ack required.

Structure
REQ-028 Shared package SHALL hold the br_type encoding, the 16 condition-code constants, the NZCV bit-index constants and the IDLE/HOLD state enum.
REQ-029 Condition evaluation (REQ-018) SHALL be a separate combinational sub-module cond_eval (inputs cond[3:0], nzcv[3:0]; output pass).
REQ-030 Structural gates SHALL carry #50 delays, consistent with the ALU; the bench SHALL allow settling time before each edge.

Verification
REQ-031 Reset then ADDS with alu flags N=0 Z=1 C=1 V=0 -> flags_q=4'b0110 next edge.
REQ-032 B.cond EQ (0000) accepted same cycle as SUBS producing Z=1, prior flags_q Z=0 -> res_valid next cycle, res_taken=1.
REQ-033 flags_q={N=1,Z=0,C=0,V=0}: B.cond GE (1010) -> taken=0; LT (1011) -> taken=1; GT (1100) -> taken=0.
REQ-034 CBZ br_regzero=1 held with res_ack=0 for 3 cycles -> res_valid=1, res_taken=1 stable, br_ready=0; then res_ack with CBNZ br_regzero=1 -> res_taken=0 next cycle, res_valid stays 1.
REQ-035 HOLD, flush=1 with br_valid=1 -> res_valid=0 next cycle, state IDLE, branch not accepted.
REQ-036 reset pulled low mid-HOLD between edges -> res_valid=0 and flags_q=0 immediately, before next clk edge.
